button_command_sequencer: RTL and testbench
===========================================

BUTTON_COMMAND_SEQUENCER -- requirements
Module: button_command_sequencer

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: i_Clk, i_Rst_L.
REQ-002 SHALL have parameter DEPTH, default 4, meaning command queue entries (power of 2, 2..16).
REQ-003 SHALL have parameter STEP_MAX, default 15, meaning upper saturation bound of o_Step (fits 4 bits).
REQ-004 Port: i_Clk  input  1  system clock, all logic on rising edge.
REQ-005 Port: i_Rst_L  input  1  asynchronous active-low reset.
REQ-006 Port: i_Buttons  input  4  one-cycle debounced press pulses; [3]=switch 1 ... [0]=switch 4.
REQ-007 Port: i_Frame_Start  input  1  one-cycle pulse at start of vertical blanking.
REQ-008 Port: o_Mode  output  2  gradient pattern select.
REQ-009 Port: o_Step  output  4  gradient increment per pixel column.
REQ-010 Port: o_Channel  output  2  colour channel being edited; 0=R, 1=G, 2=B.
REQ-011 Port: o_Update  output  1  one-cycle pulse, configuration changed this cycle.
REQ-012 Port: o_Pending  output  5  queued command count, 0..DEPTH.
REQ-013 Port: o_Drop_Count  output  8  commands lost to queue-full or same-cycle collisions; saturates at 255.

Function
REQ-014 Command encode: highest set bit of i_Buttons wins; [3]=MODE_NEXT, [2]=STEP_UP, [1]=STEP_DOWN, [0]=CHAN_NEXT.
REQ-015 Each additional set bit in the same cycle SHALL add 1 to o_Drop_Count (saturating).
REQ-016 Nonzero i_Buttons with queue not full SHALL push one 2-bit command; o_Pending reflects it next cycle.
REQ-017 Nonzero i_Buttons with queue full and no pop that cycle SHALL be dropped, o_Drop_Count +1.
REQ-018 Push and pop in the same cycle with queue full SHALL both succeed; count unchanged.
REQ-019 FSM states: IDLE (queue empty), ARMED (queue nonempty, waiting for frame), APPLY (one cycle).
REQ-020 IDLE->ARMED when registered count becomes nonzero; ARMED->APPLY on i_Frame_Start; APPLY->ARMED if count after pop >0, else IDLE.
REQ-021 i_Frame_Start in IDLE or APPLY SHALL be ignored; a command pushed in the same cycle as i_Frame_Start with empty queue waits for the next frame.
REQ-022 APPLY SHALL pop exactly one command; at most one command applied per frame.
REQ-023 New o_Mode/o_Step/o_Channel SHALL be visible, with o_Update high, in the cycle after the APPLY entry edge (frame pulse at cycle M -> outputs at M+2 edge, i.e. registered out of APPLY).
REQ-024 MODE_NEXT: o_Mode +1, wraps 3->0.
REQ-025 STEP_UP: o_Step +1, saturates at STEP_MAX; STEP_DOWN: o_Step -1, saturates at 1 (0 never produced).
REQ-026 CHAN_NEXT: o_Channel 0->1->2->0; value 3 never produced.
REQ-027 o_Update SHALL pulse even when saturation leaves o_Step unchanged.
REQ-028 Queue order strictly FIFO; read/write pointers wrap modulo DEPTH.

Reset
REQ-029 Asserting i_Rst_L low at any time, including mid-APPLY, SHALL immediately clear queue and FSM to IDLE.
REQ-030 Reset values: o_Mode=0, o_Step=1, o_Channel=0, o_Update=0, o_Pending=0, o_Drop_Count=0.
REQ-031 Inputs during reset SHALL be ignored; first push accepted on the first clock edge after deassertion.

Structure
REQ-032 Command encodings (MODE_NEXT=0, STEP_UP=1, STEP_DOWN=2, CHAN_NEXT=3), FSM state encodings and reset defaults SHALL live in a shared package.
REQ-033 The queue SHALL be a sub-module named command_fifo (push/pop/full/empty/count), instantiated once.

Verification
REQ-034 Press [3] at cycle 10, frame pulse at cycle 20 -> o_Mode 0->1 with o_Update high exactly one cycle; o_Pending 1->0.
REQ-035 i_Buttons=4'b0110 one cycle -> STEP_UP queued only, o_Drop_Count=1; next frame o_Step=2.
REQ-036 Six [2] presses, no frame, DEPTH=4 -> o_Pending=4, o_Drop_Count=2; four frames -> o_Step=5, one update per frame.
REQ-037 STEP_DOWN from o_Step=1 and [0] pressed three times -> o_Step stays 1 with o_Update pulse; o_Channel 0->1->2->0.
REQ-038 Press and frame pulse same cycle with empty queue -> no update that frame; applied on next frame pulse.
REQ-039 Reset asserted in APPLY cycle with 3 queued -> all outputs at reset values, o_Pending=0, later frames cause no update.

Source files
------------

// File: rtl/button_command_sequencer_pkg.sv
// Shared types for the button command sequencer: command and FSM encodings,
// reset defaults, and the button-to-command priority encoder.
package button_command_sequencer_pkg;

   typedef enum logic [1:0] {
      CMD_MODE_NEXT = 2'd0,
      CMD_STEP_UP   = 2'd1,
      CMD_STEP_DOWN = 2'd2,
      CMD_CHAN_NEXT = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_APPLY = 2'd2
   } state_e;

   localparam logic [1:0] MODE_RESET    = 2'd0;
   localparam logic [3:0] STEP_RESET    = 4'd1;
   localparam logic [1:0] CHANNEL_RESET = 2'd0;
   localparam logic [7:0] DROP_MAX      = 8'd255;

   // Highest set button wins; caller only uses the result when any bit is set.
   function automatic cmd_e encode_buttons(input logic [3:0] buttons);
      if (buttons[3])      return CMD_MODE_NEXT;
      else if (buttons[2]) return CMD_STEP_UP;
      else if (buttons[1]) return CMD_STEP_DOWN;
      else                 return CMD_CHAN_NEXT;
   endfunction

   // Presses that lose the priority encode in the same cycle.
   function automatic logic [2:0] extra_presses(input logic [3:0] buttons);
      logic [2:0] ones;
      ones = '0;
      for (int i = 0; i < 4; i++) ones = ones + 3'(buttons[i]);
      return (ones == 3'd0) ? 3'd0 : ones - 3'd1;
   endfunction

endpackage

// File: rtl/button_command_sequencer_command_fifo.sv
// Small FIFO of 2-bit commands; a push is accepted when full if a pop
// happens in the same cycle.
module command_fifo
   import button_command_sequencer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       push,
   input  cmd_e       push_data,
   input  logic       pop,
   output cmd_e       pop_data,
   output logic       full,
   output logic       empty,
   output logic [4:0] count
);

   localparam int AW = $clog2(DEPTH);

   cmd_e           mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           wr_en;
   logic           rd_en;

   assign full     = (count == 5'(DEPTH));
   assign empty    = (count == 5'd0);
   assign rd_en    = pop && !empty;
   assign wr_en    = push && (!full || rd_en);
   assign pop_data = mem[rd_ptr];

   // NOTE: storage has no reset; an entry is only read after it was written,
   // and the pointer/count reset below is what empties the queue.
   always_ff @(posedge i_Clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/button_command_sequencer.sv
// Queues button commands and applies at most one per video frame, during
// vertical blanking, to the gradient configuration registers.
module button_command_sequencer
   import button_command_sequencer_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int STEP_MAX = 15
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic [3:0] i_Buttons,
   input  logic       i_Frame_Start,
   output logic [1:0] o_Mode,
   output logic [3:0] o_Step,
   output logic [1:0] o_Channel,
   output logic       o_Update,
   output logic [4:0] o_Pending,
   output logic [7:0] o_Drop_Count
);

   localparam logic [3:0] STEP_TOP = 4'(STEP_MAX);

   state_e     state;
   cmd_e       push_cmd;
   cmd_e       pop_cmd;
   logic       push;
   logic       pop;
   logic       push_ok;
   logic       fifo_full;
   logic       fifo_empty;
   logic [4:0] fifo_count;
   logic [3:0] drop_inc;
   logic [8:0] drop_sum;

   assign push      = |i_Buttons;
   assign push_cmd  = encode_buttons(i_Buttons);
   assign pop       = (state == ST_APPLY) && !fifo_empty;
   assign push_ok   = push && (!fifo_full || pop);
   assign o_Pending = fifo_count;

   command_fifo #(.DEPTH(DEPTH)) u_command_fifo (
      .i_Clk     (i_Clk),
      .i_Rst_L   (i_Rst_L),
      .push      (push),
      .push_data (push_cmd),
      .pop       (pop),
      .pop_data  (pop_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Same-cycle losers plus a rejected push when the queue stays full.
   assign drop_inc = 4'(extra_presses(i_Buttons)) + 4'(push && !push_ok);
   assign drop_sum = {1'b0, o_Drop_Count} + 9'(drop_inc);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         o_Drop_Count <= '0;
      end else begin
         o_Drop_Count <= drop_sum[8] ? DROP_MAX : drop_sum[7:0];
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state     <= ST_IDLE;
         o_Mode    <= MODE_RESET;
         o_Step    <= STEP_RESET;
         o_Channel <= CHANNEL_RESET;
         o_Update  <= 1'b0;
      end else begin
         o_Update <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (fifo_count != 5'd0) state <= ST_ARMED;
            end
            ST_ARMED: begin
               if (i_Frame_Start) state <= ST_APPLY;
            end
            ST_APPLY: begin
               o_Update <= 1'b1;
               case (pop_cmd)
                  CMD_MODE_NEXT: o_Mode <= o_Mode + 2'd1;
                  CMD_STEP_UP:   if (o_Step < STEP_TOP) o_Step <= o_Step + 4'd1;
                  CMD_STEP_DOWN: if (o_Step > 4'd1) o_Step <= o_Step - 4'd1;
                  CMD_CHAN_NEXT: o_Channel <= (o_Channel == 2'd2) ? 2'd0 : o_Channel + 2'd1;
               endcase
               // Occupancy after this pop, counting a push landing this cycle.
               state <= (fifo_count > 5'd1 || push_ok) ? ST_ARMED : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_button_command_sequencer.sv
// Directed scenarios plus a randomized run checked against a queue-based
// reference model of the sequencer's behaviour.
module tb_button_command_sequencer;

   localparam int DEPTH    = 4;
   localparam int STEP_MAX = 15;

   logic       i_Clk = 1'b0;
   logic       i_Rst_L;
   logic [3:0] i_Buttons;
   logic       i_Frame_Start;
   logic [1:0] o_Mode;
   logic [3:0] o_Step;
   logic [1:0] o_Channel;
   logic       o_Update;
   logic [4:0] o_Pending;
   logic [7:0] o_Drop_Count;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: command queue, configuration, and occupancy history.
   int mq[$];
   int m_mode, m_step, m_chan, m_drop;
   bit m_update;
   bit apply_now;
   int size_prev;

   button_command_sequencer #(.DEPTH(DEPTH), .STEP_MAX(STEP_MAX)) dut (
      .i_Clk        (i_Clk),
      .i_Rst_L      (i_Rst_L),
      .i_Buttons    (i_Buttons),
      .i_Frame_Start(i_Frame_Start),
      .o_Mode       (o_Mode),
      .o_Step       (o_Step),
      .o_Channel    (o_Channel),
      .o_Update     (o_Update),
      .o_Pending    (o_Pending),
      .o_Drop_Count (o_Drop_Count)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic model_clear();
      mq.delete();
      m_mode = 0; m_step = 1; m_chan = 0; m_drop = 0;
      m_update = 0; apply_now = 0; size_prev = 0;
   endtask

   // A frame applies a command only if the queue was occupied after each of
   // the two previous edges and the previous frame's command is not being applied now.
   task automatic model_edge(input logic [3:0] b, input bit f);
      int size_before, ones, cmd;
      bit pop, acc, new_apply;
      size_before = mq.size();
      pop = apply_now && (size_before > 0);
      m_update = 0;
      if (pop) begin
         cmd = mq.pop_front();
         m_update = 1;
         case (cmd)
            0:       m_mode = (m_mode + 1) % 4;
            1:       if (m_step < STEP_MAX) m_step++;
            2:       if (m_step > 1) m_step--;
            default: m_chan = (m_chan + 1) % 3;
         endcase
      end
      ones = $countones(b);
      if (ones > 0) begin
         acc = (size_before < DEPTH) || pop;
         if (acc) mq.push_back(b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3);
         m_drop = m_drop + (ones - 1) + (acc ? 0 : 1);
         if (m_drop > 255) m_drop = 255;
      end
      new_apply = f && !apply_now && (size_before > 0) && (size_prev > 0);
      size_prev = size_before;
      apply_now = new_apply;
   endtask

   // NOTE: inputs are driven with blocking assignments on the falling edge,
   // and outputs are sampled 1 time unit after the rising edge.
   task automatic step(input logic [3:0] b, input bit f);
      @(negedge i_Clk);
      i_Buttons = b;
      i_Frame_Start = f;
      @(posedge i_Clk);
      if (i_Rst_L) model_edge(b, f);
      #1;
      i_Buttons = 4'd0;
      i_Frame_Start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge i_Clk);
      i_Rst_L = 1'b0;
      i_Buttons = 4'hF;
      i_Frame_Start = 1'b1;
      model_clear();
      repeat (2) @(negedge i_Clk);
      i_Buttons = 4'd0;
      i_Frame_Start = 1'b0;
      i_Rst_L = 1'b1;
   endtask

   task automatic test_reset();
      i_Rst_L = 1'b0; i_Buttons = 4'hF; i_Frame_Start = 1'b1;
      model_clear();
      repeat (3) @(posedge i_Clk);
      #1;
      tests_run++; if (o_Mode !== 2'd0) begin tests_failed++; $display("FAIL reset_mode: got %0d want 0", o_Mode); end
      tests_run++; if (o_Step !== 4'd1) begin tests_failed++; $display("FAIL reset_step: got %0d want 1", o_Step); end
      tests_run++; if (o_Channel !== 2'd0) begin tests_failed++; $display("FAIL reset_channel: got %0d want 0", o_Channel); end
      tests_run++; if (o_Update !== 1'b0) begin tests_failed++; $display("FAIL reset_update: got %0b want 0", o_Update); end
      tests_run++; if (o_Pending !== 5'd0) begin tests_failed++; $display("FAIL reset_pending: got %0d want 0", o_Pending); end
      tests_run++; if (o_Drop_Count !== 8'd0) begin tests_failed++; $display("FAIL reset_drop: got %0d want 0", o_Drop_Count); end
      @(negedge i_Clk);
      i_Buttons = 4'd0; i_Frame_Start = 1'b0; i_Rst_L = 1'b1;
      step(4'b0001, 1'b0);
      tests_run++; if (o_Pending !== 5'd1) begin tests_failed++; $display("FAIL first_push_after_reset: pending %0d want 1", o_Pending); end
   endtask

   task automatic test_mode_next();
      do_reset();
      repeat (9) step(4'd0, 1'b0);
      step(4'b1000, 1'b0);
      tests_run++; if (o_Pending !== 5'd1) begin tests_failed++; $display("FAIL mode_pending_queued: got %0d want 1", o_Pending); end
      repeat (9) step(4'd0, 1'b0);
      step(4'd0, 1'b1);
      tests_run++; if (o_Update !== 1'b0 || o_Mode !== 2'd0) begin tests_failed++; $display("FAIL mode_early: update %0b mode %0d want 0/0", o_Update, o_Mode); end
      step(4'd0, 1'b0);
      tests_run++; if (o_Mode !== 2'd1 || o_Update !== 1'b1) begin tests_failed++; $display("FAIL mode_apply: mode %0d update %0b want 1/1", o_Mode, o_Update); end
      tests_run++; if (o_Pending !== 5'd0) begin tests_failed++; $display("FAIL mode_pending_popped: got %0d want 0", o_Pending); end
      step(4'd0, 1'b0);
      tests_run++; if (o_Update !== 1'b0 || o_Mode !== 2'd1) begin tests_failed++; $display("FAIL mode_pulse_width: update %0b mode %0d want 0/1", o_Update, o_Mode); end
   endtask

   task automatic test_collision();
      do_reset();
      step(4'b0110, 1'b0);
      tests_run++; if (o_Drop_Count !== 8'd1 || o_Pending !== 5'd1) begin tests_failed++; $display("FAIL collision_drop: drop %0d pending %0d want 1/1", o_Drop_Count, o_Pending); end
      step(4'd0, 1'b0);
      step(4'd0, 1'b1);
      step(4'd0, 1'b0);
      tests_run++; if (o_Step !== 4'd2 || o_Update !== 1'b1) begin tests_failed++; $display("FAIL collision_step: step %0d update %0b want 2/1", o_Step, o_Update); end
   endtask

   task automatic test_queue_full();
      int updates;
      do_reset();
      repeat (6) step(4'b0100, 1'b0);
      tests_run++; if (o_Pending !== 5'd4 || o_Drop_Count !== 8'd2) begin tests_failed++; $display("FAIL full_drop: pending %0d drop %0d want 4/2", o_Pending, o_Drop_Count); end
      updates = 0;
      repeat (4) begin
         step(4'd0, 1'b1);
         if (o_Update === 1'b1) updates++;
         step(4'd0, 1'b0);
         if (o_Update === 1'b1) updates++;
         step(4'd0, 1'b0);
         if (o_Update === 1'b1) updates++;
      end
      tests_run++; if (updates != 4) begin tests_failed++; $display("FAIL full_updates: got %0d want 4", updates); end
      tests_run++; if (o_Step !== 4'd5 || o_Pending !== 5'd0) begin tests_failed++; $display("FAIL full_step: step %0d pending %0d want 5/0", o_Step, o_Pending); end
   endtask

   task automatic test_saturation_channel();
      logic [1:0] want_chan [3];
      want_chan[0] = 2'd1; want_chan[1] = 2'd2; want_chan[2] = 2'd0;
      do_reset();
      step(4'b0010, 1'b0); step(4'd0, 1'b0); step(4'd0, 1'b1); step(4'd0, 1'b0);
      tests_run++; if (o_Step !== 4'd1 || o_Update !== 1'b1) begin tests_failed++; $display("FAIL step_floor: step %0d update %0b want 1/1", o_Step, o_Update); end
      for (int i = 0; i < 3; i++) begin
         step(4'b0001, 1'b0); step(4'd0, 1'b0); step(4'd0, 1'b1); step(4'd0, 1'b0);
         tests_run++; if (o_Channel !== want_chan[i] || o_Update !== 1'b1) begin tests_failed++; $display("FAIL chan_next_%0d: chan %0d update %0b want %0d/1", i, o_Channel, o_Update, want_chan[i]); end
      end
   endtask

   task automatic test_same_cycle_frame();
      do_reset();
      step(4'b0100, 1'b1);
      step(4'd0, 1'b0);
      tests_run++; if (o_Update !== 1'b0 || o_Step !== 4'd1) begin tests_failed++; $display("FAIL same_cycle_ignored: update %0b step %0d want 0/1", o_Update, o_Step); end
      step(4'd0, 1'b0);
      step(4'd0, 1'b1);
      step(4'd0, 1'b0);
      tests_run++; if (o_Update !== 1'b1 || o_Step !== 4'd2) begin tests_failed++; $display("FAIL same_cycle_next_frame: update %0b step %0d want 1/2", o_Update, o_Step); end
   endtask

   task automatic test_reset_in_apply();
      int updates;
      do_reset();
      step(4'b1000, 1'b0); step(4'b0100, 1'b0); step(4'b0001, 1'b0); step(4'b0001, 1'b0);
      step(4'd0, 1'b1);
      #2;
      i_Rst_L = 1'b0;
      model_clear();
      #1;
      tests_run++; if (o_Pending !== 5'd0 || o_Update !== 1'b0) begin tests_failed++; $display("FAIL reset_apply_queue: pending %0d update %0b want 0/0", o_Pending, o_Update); end
      tests_run++; if (o_Mode !== 2'd0 || o_Step !== 4'd1 || o_Channel !== 2'd0 || o_Drop_Count !== 8'd0) begin
         tests_failed++; $display("FAIL reset_apply_cfg: mode %0d step %0d chan %0d drop %0d want 0/1/0/0", o_Mode, o_Step, o_Channel, o_Drop_Count);
      end
      @(negedge i_Clk);
      i_Rst_L = 1'b1;
      updates = 0;
      repeat (3) begin
         step(4'd0, 1'b1);
         if (o_Update === 1'b1) updates++;
         step(4'd0, 1'b0);
         if (o_Update === 1'b1) updates++;
      end
      tests_run++; if (updates != 0 || o_Mode !== 2'd0) begin tests_failed++; $display("FAIL reset_apply_quiet: updates %0d mode %0d want 0/0", updates, o_Mode); end
   endtask

   task automatic test_drop_saturate();
      do_reset();
      repeat (90) step(4'hF, 1'b0);
      tests_run++; if (o_Drop_Count !== 8'd255 || o_Pending !== 5'd4) begin tests_failed++; $display("FAIL drop_saturate: drop %0d pending %0d want 255/4", o_Drop_Count, o_Pending); end
   endtask

   task automatic test_random();
      logic [3:0] b;
      bit f;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         b = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'd0;
         f = ($urandom_range(0, 3) == 0);
         step(b, f);
         tests_run++; if (o_Mode !== 2'(m_mode)) begin tests_failed++; $display("FAIL rand_mode@%0d: got %0d want %0d", i, o_Mode, m_mode); end
         tests_run++; if (o_Step !== 4'(m_step)) begin tests_failed++; $display("FAIL rand_step@%0d: got %0d want %0d", i, o_Step, m_step); end
         tests_run++; if (o_Channel !== 2'(m_chan)) begin tests_failed++; $display("FAIL rand_chan@%0d: got %0d want %0d", i, o_Channel, m_chan); end
         tests_run++; if (o_Update !== m_update) begin tests_failed++; $display("FAIL rand_update@%0d: got %0b want %0b", i, o_Update, m_update); end
         tests_run++; if (o_Pending !== 5'(mq.size())) begin tests_failed++; $display("FAIL rand_pending@%0d: got %0d want %0d", i, o_Pending, mq.size()); end
         tests_run++; if (o_Drop_Count !== 8'(m_drop)) begin tests_failed++; $display("FAIL rand_drop@%0d: got %0d want %0d", i, o_Drop_Count, m_drop); end
      end
   endtask

   initial begin
      i_Buttons = 4'd0;
      i_Frame_Start = 1'b0;
      test_reset();
      test_mode_next();
      test_collision();
      test_queue_full();
      test_saturation_channel();
      test_same_cycle_frame();
      test_reset_in_apply();
      test_drop_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
